// File: rtl/mem_io_pkg.sv
// Shared types and helpers for the SLC-3 SRAM / memory-mapped I/O bridge.
package mem_io_pkg;

  // Bridge sequencing states. IO_DONE bypasses the SRAM strobe sequence.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    DONE    = 3'd3,
    IO_DONE = 3'd4
  } state_t;

  // Level of an inactive active-low SRAM strobe.
  localparam logic STROBE_OFF = 1'b1;

  // True when a word address falls in the I/O window [base, top of space].
  // Arguments are zero-extended to 32 bits by the caller.
  function automatic logic is_io(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/mem_io_port_bank.sv
// Memory-mapped I/O words: byte-enabled hex display registers and a switch
// read mux. Offsets at or beyond N_IO read as zero and drop writes.
module mem_io_port_bank
  import mem_io_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int N_IO   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        offset,
  input  logic [1:0]               be,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [N_IO*DATA_W-1:0]   switches,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_IO*DATA_W-1:0]   hex_words
);

  localparam int HALF = DATA_W / 2;

  logic [DATA_W-1:0] hex_q [N_IO];

  // Hex registers: each byte lane updates only when its enable is set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N_IO; k++) hex_q[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_IO; k++) begin
        if (offset == ADDR_W'(k)) begin
          if (be[0]) hex_q[k][HALF-1:0]      <= wdata[HALF-1:0];
          if (be[1]) hex_q[k][DATA_W-1:HALF] <= wdata[DATA_W-1:HALF];
        end
      end
    end
  end

  // Switch read mux; no match leaves the default zero.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (offset == ADDR_W'(k)) rdata = switches[k*DATA_W +: DATA_W];
    end
  end

  // Flatten the hex registers onto the output bus, word k at slice k.
  always_comb begin
    hex_words = '0;
    for (int k = 0; k < N_IO; k++) hex_words[k*DATA_W +: DATA_W] = hex_q[k];
  end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU request/ready to asynchronous SRAM bridge with programmable wait states
// and a small memory-mapped I/O window at the top of the address space.
// Handshake: the CPU raises cpu_req in IDLE with its command on cpu_*; the
// bridge registers it on that edge and later returns a one-cycle cpu_ready
// pulse (with cpu_rdata for reads). cpu_req outside IDLE is ignored.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int                    DATA_W      = 16,
  parameter int                    CPU_ADDR_W  = 16,
  parameter int                    SRAM_ADDR_W = 20,
  parameter int                    WAIT_STATES = 2,
  parameter int                    N_IO        = 2,
  parameter logic [CPU_ADDR_W-1:0] IO_BASE     = 16'hFFFE
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [1:0]               cpu_be,
  input  logic [CPU_ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic                     cpu_ready,
  output logic [DATA_W-1:0]        cpu_rdata,
  input  logic [N_IO*DATA_W-1:0]   Switches,
  output logic [N_IO*DATA_W-1:0]   hex_words,
  output logic                     Mem_CE,
  output logic                     Mem_OE,
  output logic                     Mem_WE,
  output logic                     Mem_UB,
  output logic                     Mem_LB,
  output logic [SRAM_ADDR_W-1:0]   SRAM_ADDR,
  output logic [DATA_W-1:0]        Data_to_SRAM,
  output logic                     sram_drive,
  input  logic [DATA_W-1:0]        Data_from_SRAM,
  output logic [2:0]               dbg_state
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t                state;
  logic                  we_q;
  logic [3:0]            wait_cnt;
  logic                  io_hit;
  logic                  io_wr;
  logic [CPU_ADDR_W-1:0] io_offset;
  logic [DATA_W-1:0]     io_rdata;

  assign io_hit    = is_io(32'(cpu_addr), 32'(IO_BASE));
  assign io_offset = cpu_addr - IO_BASE;
  assign io_wr     = (state == IDLE) && cpu_req && io_hit && cpu_we;
  assign dbg_state = state;

  mem_io_port_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (CPU_ADDR_W),
    .N_IO   (N_IO)
  ) u_port_bank (
    .clk       (Clk),
    .reset     (Reset),
    .wr_en     (io_wr),
    .offset    (io_offset),
    .be        (cpu_be),
    .wdata     (cpu_wdata),
    .switches  (Switches),
    .rdata     (io_rdata),
    .hex_words (hex_words)
  );

  // Sequencer with registered strobes; reset drops every strobe on the same
  // edge even mid-access.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      wait_cnt     <= '0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      Mem_CE       <= STROBE_OFF;
      Mem_OE       <= STROBE_OFF;
      Mem_WE       <= STROBE_OFF;
      Mem_UB       <= STROBE_OFF;
      Mem_LB       <= STROBE_OFF;
      SRAM_ADDR    <= '0;
      Data_to_SRAM <= '0;
      sram_drive   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b0;
          if (cpu_req) begin
            if (io_hit) begin
              state     <= IO_DONE;
              cpu_ready <= 1'b1;
              if (!cpu_we) cpu_rdata <= io_rdata;
            end else begin
              state      <= SETUP;
              we_q       <= cpu_we;
              SRAM_ADDR  <= SRAM_ADDR_W'(cpu_addr);
              if (cpu_we) Data_to_SRAM <= cpu_wdata;
              Mem_CE     <= 1'b0;
              // Reads always fetch both bytes.
              Mem_UB     <= cpu_we ? ~cpu_be[1] : 1'b0;
              Mem_LB     <= cpu_we ? ~cpu_be[0] : 1'b0;
              sram_drive <= cpu_we;
            end
          end
        end
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= WS;
          Mem_OE   <= we_q;
          Mem_WE   <= ~we_q;
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state     <= DONE;
            Mem_OE    <= STROBE_OFF;
            Mem_WE    <= STROBE_OFF;
            cpu_ready <= 1'b1;
            if (!we_q) cpu_rdata <= Data_from_SRAM;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          // Write data stayed driven through DONE as hold time; release now.
          state      <= IDLE;
          cpu_ready  <= 1'b0;
          Mem_CE     <= STROBE_OFF;
          Mem_UB     <= STROBE_OFF;
          Mem_LB     <= STROBE_OFF;
          sram_drive <= 1'b0;
        end
        IO_DONE: begin
          state     <= IDLE;
          cpu_ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: a main instance (2 wait states, 2 I/O
// words), a zero-wait-state instance and a single-I/O-word instance share the
// CPU-side inputs; a small SRAM model answers the main instance.
module tb_mem_io_bridge;
  import mem_io_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_be = 2'b00;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [31:0] Switches = '0;
  logic [15:0] Data_from_SRAM;

  // main instance
  logic        m_ready, m_ce, m_oe, m_we, m_ub, m_lb, m_drive;
  logic [15:0] m_rdata, m_dout;
  logic [31:0] m_hex;
  logic [19:0] m_sram_addr;
  logic [2:0]  m_state;
  // zero wait state instance
  logic        w_ready, w_ce, w_oe, w_we, w_ub, w_lb, w_drive;
  logic [15:0] w_rdata, w_dout;
  logic [31:0] w_hex;
  logic [19:0] w_sram_addr;
  logic [2:0]  w_state;
  // single I/O word instance
  logic        n_ready, n_ce, n_oe, n_we, n_ub, n_lb, n_drive;
  logic [15:0] n_rdata, n_dout, n_hex;
  logic [19:0] n_sram_addr;
  logic [2:0]  n_state;

  mem_io_bridge #(.WAIT_STATES(2), .N_IO(2)) dut (
    .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(m_ready), .cpu_rdata(m_rdata),
    .Switches(Switches), .hex_words(m_hex), .Mem_CE(m_ce), .Mem_OE(m_oe), .Mem_WE(m_we),
    .Mem_UB(m_ub), .Mem_LB(m_lb), .SRAM_ADDR(m_sram_addr), .Data_to_SRAM(m_dout),
    .sram_drive(m_drive), .Data_from_SRAM(Data_from_SRAM), .dbg_state(m_state));

  mem_io_bridge #(.WAIT_STATES(0), .N_IO(2)) dut_w0 (
    .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(w_ready), .cpu_rdata(w_rdata),
    .Switches(Switches), .hex_words(w_hex), .Mem_CE(w_ce), .Mem_OE(w_oe), .Mem_WE(w_we),
    .Mem_UB(w_ub), .Mem_LB(w_lb), .SRAM_ADDR(w_sram_addr), .Data_to_SRAM(w_dout),
    .sram_drive(w_drive), .Data_from_SRAM(Data_from_SRAM), .dbg_state(w_state));

  mem_io_bridge #(.WAIT_STATES(2), .N_IO(1)) dut_n1 (
    .Clk(Clk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(n_ready), .cpu_rdata(n_rdata),
    .Switches(Switches[15:0]), .hex_words(n_hex), .Mem_CE(n_ce), .Mem_OE(n_oe), .Mem_WE(n_we),
    .Mem_UB(n_ub), .Mem_LB(n_lb), .SRAM_ADDR(n_sram_addr), .Data_to_SRAM(n_dout),
    .sram_drive(n_drive), .Data_from_SRAM(Data_from_SRAM), .dbg_state(n_state));

  // clock / reset block
  always #5 Clk = ~Clk;

  // SRAM model driven by the main instance's strobes
  logic [15:0] sram_mem [256];
  initial for (int i = 0; i < 256; i++) sram_mem[i] = '0;
  assign Data_from_SRAM = sram_mem[m_sram_addr[7:0]];
  always @(posedge Clk) begin
    if (!m_ce && !m_we && m_drive) begin
      if (!m_ub) sram_mem[m_sram_addr[7:0]][15:8] <= m_dout[15:8];
      if (!m_lb) sram_mem[m_sram_addr[7:0]][7:0]  <= m_dout[7:0];
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // observations from the last transaction
  int          m_we_low, m_oe_low, m_any_low, m_rdy_cyc, m_rdy_cnt, w_rdy_cyc;
  logic [15:0] m_rd, w_rd, n_rd;
  logic [1:0]  m_ublb;

  // driver: issue one request, then watch 12 cycles (cycle 1 follows the
  // accept edge). Inputs are scrambled after acceptance; ghost re-raises
  // cpu_req during ACCESS (cycle 3) and DONE (cycle 5) of the main instance.
  task automatic run_txn(input logic we, input logic [1:0] be, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit ghost);
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge Clk);
    m_we_low = 0; m_oe_low = 0; m_any_low = 0; m_rdy_cyc = 0; m_rdy_cnt = 0; w_rdy_cyc = 0;
    m_rd = 'x; w_rd = 'x; n_rd = 'x; m_ublb = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (ghost && (c == 3 || c == 5)) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 16'hFFFE; cpu_wdata = 16'hFFFF;
      end else begin
        cpu_req = 1'b0; cpu_we = ~we; cpu_be = ~be; cpu_addr = ~addr; cpu_wdata = ~wdata;
      end
      if (!(m_ce && m_oe && m_we && m_ub && m_lb)) m_any_low++;
      if (!m_we) m_we_low++;
      if (!m_oe) m_oe_low++;
      if (c == 2) m_ublb = {m_ub, m_lb};
      if (m_ready) begin
        m_rdy_cnt++;
        if (m_rdy_cyc == 0) begin m_rdy_cyc = c; m_rd = m_rdata; end
      end
      if (w_ready && w_rdy_cyc == 0) begin w_rdy_cyc = c; w_rd = w_rdata; end
      if (n_ready && n_rd === 16'hxxxx) n_rd = n_rdata;
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    // reset
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_strobes", {m_ce, m_oe, m_we, m_ub, m_lb}, 5'b11111);
    check("rst_drive_ready", {m_drive, m_ready}, 2'b00);
    check("rst_rdata", m_rdata, 16'h0000);
    check("rst_hex", m_hex, 32'h0);
    check("rst_addr", m_sram_addr, 20'h0);
    check("rst_state", m_state, 3'(IDLE));
    Reset = 1'b1;

    // SRAM write 0xBEEF @0x0010, both bytes
    run_txn(1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0);
    check("wr_we_low", m_we_low, 3);
    check("wr_oe_low", m_oe_low, 0);
    check("wr_ready_cyc", m_rdy_cyc, 5);
    check("wr_ready_cnt", m_rdy_cnt, 1);
    check("wr_w0_ready_cyc", w_rdy_cyc, 3);
    check("wr_sram_addr", m_sram_addr, 20'h00010);
    check("wr_mem", sram_mem[16], 16'hBEEF);

    // SRAM read back
    run_txn(1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0);
    check("rd_oe_low", m_oe_low, 3);
    check("rd_we_low", m_we_low, 0);
    check("rd_ready_cyc", m_rdy_cyc, 5);
    check("rd_data", m_rd, 16'hBEEF);
    check("rd_w0_ready_cyc", w_rdy_cyc, 3);
    check("rd_w0_data", w_rd, 16'hBEEF);
    check("rd_ublb", m_ublb, 2'b00);

    // partial SRAM write: upper byte only
    run_txn(1'b1, 2'b10, 16'h0020, 16'h1234, 1'b0);
    check("pw_ublb", m_ublb, 2'b01);
    check("pw_mem", sram_mem[32], 16'h1200);

    // I/O write, lower byte only
    run_txn(1'b1, 2'b01, 16'hFFFE, 16'h12AB, 1'b0);
    check("io_wr_hex0", m_hex[15:0], 16'h00AB);
    check("io_wr_ready_cyc", m_rdy_cyc, 1);
    check("io_wr_ready_cnt", m_rdy_cnt, 1);
    check("io_wr_no_strobe", m_any_low, 0);
    check("io_wr_rdata_hold", m_rd, 16'hBEEF);

    // I/O write upper byte of word0, then full word1
    run_txn(1'b1, 2'b10, 16'hFFFE, 16'h3400, 1'b0);
    check("io_wr_hex0_ub", m_hex[15:0], 16'h34AB);
    run_txn(1'b1, 2'b11, 16'hFFFF, 16'hC0DE, 1'b0);
    check("io_wr_hex1", m_hex, 32'hC0DE_34AB);
    check("n1_hex_oob_ignored", n_hex, 16'h34AB);

    // I/O reads
    Switches = {16'h5A5A, 16'h1111};
    run_txn(1'b0, 2'b00, 16'hFFFF, 16'h0000, 1'b0);
    check("io_rd_sw1", m_rd, 16'h5A5A);
    check("io_rd_ready_cyc", m_rdy_cyc, 1);
    check("n1_rd_oob", n_rd, 16'h0000);
    run_txn(1'b0, 2'b00, 16'hFFFE, 16'h0000, 1'b0);
    check("io_rd_sw0", m_rd, 16'h1111);
    check("io_rd_no_strobe", m_any_low, 0);

    // requests during ACCESS/DONE must be ignored
    run_txn(1'b1, 2'b11, 16'h0030, 16'h7777, 1'b1);
    check("ghost_ready_cnt", m_rdy_cnt, 1);
    check("ghost_ready_cyc", m_rdy_cyc, 5);
    check("ghost_hex_kept", m_hex, 32'hC0DE_34AB);
    check("ghost_mem", sram_mem[48], 16'h7777);

    // reset asserted mid-ACCESS
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 16'h0040; cpu_wdata = 16'h9999;
    @(posedge Clk);
    @(negedge Clk); cpu_req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("abort_in_access", m_state, 3'(ACCESS));
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_strobes", {m_ce, m_oe, m_we, m_ub, m_lb}, 5'b11111);
    check("abort_drive_ready", {m_drive, m_ready}, 2'b00);
    check("abort_state", m_state, 3'(IDLE));
    check("abort_hex", m_hex, 32'h0);
    Reset = 1'b1;

    // recovery read after reset
    run_txn(1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0);
    check("recover_rd", m_rd, 16'hBEEF);
    check("recover_ready_cyc", m_rdy_cyc, 5);

    exp_q.delete();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
